// File: rtl/hdc_msg_scheduler.sv
// Sequencer for the HDC SMS classifier: streams one latched message into the
// encoder, then trains a class or scores HAM/SPAM and emits a verdict.
module hdc_msg_scheduler #(
    parameter int MESSAGE_LENGTH = 160,
    parameter int CHAR_LENGTH    = 8,
    parameter int SCORE_WIDTH    = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic                                train,
    input  logic [CHAR_LENGTH*MESSAGE_LENGTH-1:0] msg,
    input  logic [7:0]                          length,
    input  logic [1:0]                          label,
    output logic                                busy,
    output logic                                char_valid,
    output logic [CHAR_LENGTH-1:0]              char_data,
    output logic                                char_last,
    input  logic                                char_ready,
    input  logic                                enc_done,
    output logic                                train_en,
    output logic [1:0]                          train_class,
    output logic                                cmp_req,
    output logic                                cmp_class,
    input  logic                                cmp_ack,
    input  logic [SCORE_WIDTH-1:0]              cmp_score,
    output logic [1:0]                          result,
    output logic                                result_valid
);

    localparam int         MSG_W   = CHAR_LENGTH * MESSAGE_LENGTH;
    localparam logic [7:0] MAX_LEN = 8'(MESSAGE_LENGTH);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_ENC,
        TRAIN,
        CMP0,
        CMP1,
        DONE
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [MSG_W-1:0]       msg_q;
    logic [7:0]             leff_q;
    logic [7:0]             idx_q;
    logic [1:0]             label_q;
    logic                   train_q;
    logic [SCORE_WIDTH-1:0] score0_q;
    logic [1:0]             result_q;
    logic [7:0]             leff_in;
    logic                   at_last;

    assign leff_in = (length > MAX_LEN) ? MAX_LEN : length;
    assign at_last = (idx_q == leff_q - 8'd1);

    function automatic logic [1:0] decide(
        input logic [SCORE_WIDTH-1:0] s0,
        input logic [SCORE_WIDTH-1:0] s1
    );
        if (s0 > s1)
            return 2'b00;
        else if (s1 > s0)
            return 2'b01;
        else
            return 2'b11;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start)
                    state_d = (leff_in == 8'd0) ? DONE : SEND;
            end
            SEND: begin
                if (char_ready && at_last)
                    state_d = WAIT_ENC;
            end
            WAIT_ENC: begin
                if (enc_done)
                    state_d = train_q ? TRAIN : CMP0;
            end
            TRAIN: state_d = DONE;
            CMP0: begin
                if (cmp_ack)
                    state_d = CMP1;
            end
            CMP1: begin
                if (cmp_ack)
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The message is kept as a shift register so the current char is always on top.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            msg_q    <= '0;
            leff_q   <= 8'd0;
            idx_q    <= 8'd0;
            label_q  <= 2'b00;
            train_q  <= 1'b0;
            score0_q <= '0;
            result_q <= 2'b11;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        msg_q    <= msg;
                        leff_q   <= leff_in;
                        idx_q    <= 8'd0;
                        label_q  <= label;
                        train_q  <= train;
                        score0_q <= '0;
                        if (leff_in == 8'd0 && !train)
                            result_q <= 2'b11;
                    end
                end
                SEND: begin
                    if (char_ready) begin
                        idx_q <= idx_q + 8'd1;
                        msg_q <= msg_q << CHAR_LENGTH;
                    end
                end
                CMP0: begin
                    if (cmp_ack)
                        score0_q <= cmp_score;
                end
                CMP1: begin
                    if (cmp_ack)
                        result_q <= decide(score0_q, cmp_score);
                end
                default: ;
            endcase
        end
    end

    assign busy         = (state_q != IDLE);
    assign char_valid   = (state_q == SEND);
    assign char_data    = char_valid ? msg_q[MSG_W-1 -: CHAR_LENGTH] : '0;
    assign char_last    = char_valid && at_last;
    assign train_en     = (state_q == TRAIN);
    assign train_class  = train_en ? label_q : 2'b00;
    assign cmp_req      = (state_q == CMP0) || (state_q == CMP1);
    assign cmp_class    = (state_q == CMP1);
    assign result       = result_q;
    assign result_valid = (state_q == DONE) && !train_q;

endmodule

// File: tb/tb_hdc_msg_scheduler.sv
// Directed bench for hdc_msg_scheduler: vector table plus
// handshake-stall and reset sequences.
module tb_hdc_msg_scheduler;

    localparam int ML = 160;
    localparam int CL = 8;
    localparam int SW = 16;
    localparam int MW = ML * CL;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          train;
    logic [MW-1:0] msg;
    logic [7:0]    length;
    logic [1:0]    label;
    logic          busy;
    logic          char_valid;
    logic [CL-1:0] char_data;
    logic          char_last;
    logic          char_ready;
    logic          enc_done;
    logic          train_en;
    logic [1:0]    train_class;
    logic          cmp_req;
    logic          cmp_class;
    logic          cmp_ack;
    logic [SW-1:0] cmp_score;
    logic [1:0]    result;
    logic          result_valid;

    int checks = 0;
    int failures = 0;
    logic [1:0] last_res = 2'b11;

    always #5 clk = ~clk;

    hdc_msg_scheduler #(
        .MESSAGE_LENGTH(ML),
        .CHAR_LENGTH(CL),
        .SCORE_WIDTH(SW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .train(train),
        .msg(msg),
        .length(length),
        .label(label),
        .busy(busy),
        .char_valid(char_valid),
        .char_data(char_data),
        .char_last(char_last),
        .char_ready(char_ready),
        .enc_done(enc_done),
        .train_en(train_en),
        .train_class(train_class),
        .cmp_req(cmp_req),
        .cmp_class(cmp_class),
        .cmp_ack(cmp_ack),
        .cmp_score(cmp_score),
        .result(result),
        .result_valid(result_valid)
    );

    typedef struct packed {
        logic        tr;
        logic [7:0]  len;
        logic [1:0]  lab;
        logic [31:0] txt;
        logic [15:0] s0;
        logic [15:0] s1;
        logic [1:0]  exp;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // chars 0..3 from txt (MSB first), the rest a fixed pattern
    function automatic logic [MW-1:0] build(input logic [31:0] txt);
        logic [MW-1:0] v;
        logic [7:0]    c;
        v = '0;
        for (int i = 0; i < ML; i++) begin
            if (i < 4)
                c = txt[31-8*i -: 8];
            else
                c = 8'(i * 3 + 1);
            v[CL*(ML-1-i) +: CL] = c;
        end
        return v;
    endfunction

    function automatic logic [7:0] ch_of(input logic [MW-1:0] m, input int k);
        return m[CL*(ML-1-k) +: CL];
    endfunction

    task automatic run_vec(input vec_t v);
        logic [MW-1:0] mv;
        int leff;
        mv = build(v.txt);
        leff = (v.len > 8'(ML)) ? ML : int'(v.len);
        start = 1'b1;
        train = v.tr;
        length = v.len;
        label = v.lab;
        msg = mv;
        char_ready = 1'b1;
        cmp_ack = 1'b1;
        cmp_score = '0;
        enc_done = 1'b0;
        step();
        start = 1'b0;
        msg = ~mv;
        length = 8'd1;
        label = ~v.lab;
        train = ~v.tr;
        if (leff == 0) begin
            chk("zero_busy", 32'(busy), 1);
            chk("zero_char_valid", 32'(char_valid), 0);
            chk("zero_train_en", 32'(train_en), 0);
            chk("zero_result_valid", 32'(result_valid), 32'(!v.tr));
            if (!v.tr)
                last_res = v.exp;
            chk("zero_result", 32'(result), 32'(last_res));
            step();
            chk("zero_idle", 32'(busy), 0);
            chk("zero_result_hold", 32'(result), 32'(last_res));
            return;
        end
        for (int k = 0; k < leff; k++) begin
            chk("char_valid", 32'(char_valid), 1);
            chk("char_data", 32'(char_data), 32'(ch_of(mv, k)));
            chk("char_last", 32'(char_last), 32'(k == leff - 1));
            step();
        end
        chk("wait_enc_valid", 32'(char_valid), 0);
        chk("wait_enc_busy", 32'(busy), 1);
        enc_done = 1'b1;
        step();
        enc_done = 1'b0;
        if (v.tr) begin
            chk("train_en", 32'(train_en), 1);
            chk("train_class", 32'(train_class), 32'(v.lab));
            chk("train_no_cmp", 32'(cmp_req), 0);
            step();
            chk("train_en_off", 32'(train_en), 0);
            chk("train_no_rv", 32'(result_valid), 0);
            chk("train_done_busy", 32'(busy), 1);
            step();
            chk("train_idle", 32'(busy), 0);
            chk("train_result_hold", 32'(result), 32'(last_res));
            chk("train_no_rv2", 32'(result_valid), 0);
        end else begin
            chk("cmp0_req", 32'(cmp_req), 1);
            chk("cmp0_class", 32'(cmp_class), 0);
            cmp_score = v.s0;
            step();
            chk("cmp1_req", 32'(cmp_req), 1);
            chk("cmp1_class", 32'(cmp_class), 1);
            chk("cmp1_no_rv", 32'(result_valid), 0);
            cmp_score = v.s1;
            step();
            cmp_score = 16'hdead;
            chk("done_rv", 32'(result_valid), 1);
            chk("done_result", 32'(result), 32'(v.exp));
            chk("done_no_req", 32'(cmp_req), 0);
            chk("done_busy", 32'(busy), 1);
            last_res = v.exp;
            step();
            chk("inf_idle", 32'(busy), 0);
            chk("inf_rv_off", 32'(result_valid), 0);
            chk("inf_result_hold", 32'(result), 32'(last_res));
        end
    endtask

    task automatic chk_reset_vals;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_char_valid", 32'(char_valid), 0);
        chk("rst_char_data", 32'(char_data), 0);
        chk("rst_char_last", 32'(char_last), 0);
        chk("rst_train_en", 32'(train_en), 0);
        chk("rst_train_class", 32'(train_class), 0);
        chk("rst_cmp_req", 32'(cmp_req), 0);
        chk("rst_cmp_class", 32'(cmp_class), 0);
        chk("rst_result", 32'(result), 3);
        chk("rst_result_valid", 32'(result_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [MW-1:0] mv;
        logic [3:0]    pat;
        int k;
        int cyc;
        vec_t vb;

        //        tr    len     lab    txt           s0        s1        exp
        vecs[0] = '{1'b0, 8'd3,   2'b00, 32'h61626300, 16'd40,   16'd25,   2'b00};
        vecs[1] = '{1'b0, 8'd3,   2'b00, 32'h78797a00, 16'd10,   16'd10,   2'b11};
        vecs[2] = '{1'b0, 8'd4,   2'b00, 32'h7370616d, 16'd5,    16'd900,  2'b01};
        vecs[3] = '{1'b1, 8'd2,   2'b01, 32'h68690000, 16'd0,    16'd0,    2'b00};
        vecs[4] = '{1'b0, 8'd0,   2'b00, 32'h41424344, 16'd0,    16'd0,    2'b11};
        vecs[5] = '{1'b1, 8'd0,   2'b01, 32'h41424344, 16'd0,    16'd0,    2'b00};
        vecs[6] = '{1'b0, 8'd1,   2'b00, 32'h71000000, 16'hffff, 16'hfffe, 2'b00};
        vecs[7] = '{1'b1, 8'd3,   2'b00, 32'h6e6f7000, 16'd0,    16'd0,    2'b00};
        vecs[8] = '{1'b0, 8'd2,   2'b00, 32'h6b6c0000, 16'd1,    16'h8000, 2'b01};
        vecs[9] = '{1'b0, 8'd200, 2'b00, 32'h4c4f4e47, 16'd7,    16'd3,    2'b00};

        reset = 1'b1;
        start = 1'b0;
        train = 1'b0;
        msg = '0;
        length = 8'd0;
        label = 2'b00;
        char_ready = 1'b0;
        enc_done = 1'b0;
        cmp_ack = 1'b0;
        cmp_score = '0;
        #3;
        chk_reset_vals();
        step();
        #2 reset = 1'b0;
        step();

        for (int i = 0; i < 10; i++)
            run_vec(vecs[i]);

        // ready stalls 1,0,0,1 and acks delayed by four cycles
        mv = build(32'h7778797a);
        start = 1'b1;
        train = 1'b0;
        length = 8'd4;
        msg = mv;
        char_ready = 1'b1;
        cmp_ack = 1'b0;
        step();
        start = 1'b0;
        pat = 4'b1001;
        k = 0;
        cyc = 0;
        while (k < 4 && cyc < 40) begin
            char_ready = pat[3 - (cyc % 4)];
            enc_done = (cyc == 0);
            start = (cyc == 1);
            chk("stall_valid", 32'(char_valid), 1);
            chk("stall_data", 32'(char_data), 32'(ch_of(mv, k)));
            chk("stall_last", 32'(char_last), 32'(k == 3));
            if (char_ready)
                k++;
            cyc++;
            step();
        end
        start = 1'b0;
        enc_done = 1'b0;
        char_ready = 1'b1;
        chk("stall_count", 32'(k), 4);
        chk("stall_cycles", 32'(cyc), 8);
        chk("stall_wait_enc", 32'(char_valid), 0);
        enc_done = 1'b1;
        step();
        enc_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("hold0_req", 32'(cmp_req), 1);
            chk("hold0_class", 32'(cmp_class), 0);
            cmp_score = 16'd999;
            step();
        end
        chk("ack0_req", 32'(cmp_req), 1);
        cmp_ack = 1'b1;
        cmp_score = 16'd300;
        step();
        cmp_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("hold1_req", 32'(cmp_req), 1);
            chk("hold1_class", 32'(cmp_class), 1);
            cmp_score = 16'd1000;
            step();
        end
        cmp_ack = 1'b1;
        cmp_score = 16'd200;
        step();
        cmp_ack = 1'b0;
        chk("stall_rv", 32'(result_valid), 1);
        chk("stall_result", 32'(result), 0);
        last_res = 2'b00;
        step();
        chk("stall_idle", 32'(busy), 0);
        step();
        chk("start_not_queued", 32'(busy), 0);

        // reset mid-SEND with start held high throughout
        mv = build(32'h31323334);
        start = 1'b1;
        train = 1'b0;
        length = 8'd5;
        msg = mv;
        char_ready = 1'b1;
        cmp_ack = 1'b1;
        step();
        chk("pre_rst_c0", 32'(char_data), 32'(ch_of(mv, 0)));
        step();
        chk("busy_start_ignored", 32'(char_data), 32'(ch_of(mv, 1)));
        step();
        #2 reset = 1'b1;
        #1;
        chk_reset_vals();
        last_res = 2'b11;
        #2 reset = 1'b0;
        vb = '{1'b0, 8'd2, 2'b00, 32'h6f6b0000, 16'd3, 16'd9, 2'b01};
        run_vec(vb);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
